acc_feeder: RTL and testbench

Upstream sequencer for the systolic accelerator core. Accepts a 32-bit valid/ready word stream from the user-project bus side and buffers it in a small FIFO. Replays it to the core as the valid-burst pattern the core expects: contiguous 12-word bursts with idle gaps for matrix multiply, and 11 taps followed by spaced single samples for FIR. Holds `func_sel` stable for the whole job.

---
 rtl/acc_feeder_pkg.sv | 22 ++
 rtl/acc_feeder_fifo.sv | 60 ++++++
 rtl/acc_feeder.sv | 182 ++++++++++++++++++
 tb/tb_acc_feeder.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_feeder_pkg.sv
// Shared types and constants for the accelerator feeder.
package acc_feeder_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StMmWait,
        StMmBurst,
        StMmGap,
        StFirTap,
        StFirWait,
        StFirData,
        StFirGap,
        StDone
    } state_e;

    localparam logic MODE_MM  = 1'b0;
    localparam logic MODE_FIR = 1'b1;

    localparam int unsigned MM_BURST_LEN = 12;
    localparam int unsigned FIR_TAPS     = 11;

endpackage

// File: rtl/acc_feeder_fifo.sv
// Synchronous input buffer with registered occupancy count and power-of-two wrapping pointers.
module acc_feeder_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        push_i,
    input  logic [DATA_WIDTH-1:0]       wdata_i,
    input  logic                        pop_i,
    output logic [DATA_WIDTH-1:0]       rdata_o,
    output logic [$clog2(FIFO_DEPTH):0] count_o,
    output logic                        full_o,
    output logic                        empty_o
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]       wptr_q, wptr_d;
    logic [PtrW-1:0]       rptr_q, rptr_d;
    logic [CntW-1:0]       count_q, count_d;
    logic                  do_push;
    logic                  do_pop;

    assign full_o  = (count_q == CntW'(FIFO_DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];

    // A push while full is still accepted when a pop frees the slot in the same cycle.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q + CntW'(do_push) - CntW'(do_pop);
        if (do_push) wptr_d = wptr_q + PtrW'(1);
        if (do_pop)  rptr_d = rptr_q + PtrW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/acc_feeder.sv
// Buffers a valid/ready word stream and replays it to the systolic core as MM bursts or
// FIR taps followed by spaced samples.
module acc_feeder
    import acc_feeder_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned MM_GAP     = 8,
    parameter int unsigned FIR_GAP    = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  cfg_func_sel,
    input  logic [15:0]           cfg_count,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    output logic [DATA_WIDTH-1:0] acc_data_o,
    output logic                  acc_data_valid_o,
    output logic                  func_sel_o,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

    state_e                state_q, state_d;
    logic [3:0]            phase_q, phase_d;
    logic [3:0]            gap_q, gap_d;
    logic [15:0]           job_q, job_d;
    logic                  func_sel_q, func_sel_d;
    logic [DATA_WIDTH-1:0] acc_data_q, acc_data_d;
    logic                  valid_q, valid_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  pop;
    logic [DATA_WIDTH-1:0] fifo_rdata;
    logic [CntW-1:0]       fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;

    assign s_tready = ~fifo_full;

    acc_feeder_fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i  (clk),
        .rst_i  (rst),
        .push_i (s_tvalid & s_tready),
        .wdata_i(s_tdata),
        .pop_i  (pop),
        .rdata_o(fifo_rdata),
        .count_o(fifo_count),
        .full_o (fifo_full),
        .empty_o(fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            phase_q    <= '0;
            gap_q      <= '0;
            job_q      <= '0;
            func_sel_q <= 1'b0;
            acc_data_q <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            gap_q      <= gap_d;
            job_q      <= job_d;
            func_sel_q <= func_sel_d;
            acc_data_q <= acc_data_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Words are popped on the edge that enters or advances an issuing phase, so each word
    // lands in the output register one cycle after the FIFO can supply it.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        gap_d      = gap_q;
        job_d      = job_q;
        func_sel_d = func_sel_q;
        pop        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    func_sel_d = cfg_func_sel;
                    job_d      = cfg_count;
                    phase_d    = '0;
                    gap_d      = '0;
                    if (cfg_count == '0)            state_d = StDone;
                    else if (cfg_func_sel == MODE_FIR) state_d = StFirTap;
                    else                            state_d = StMmWait;
                end
            end
            StMmWait: begin
                if (fifo_count >= CntW'(MM_BURST_LEN)) begin
                    pop     = 1'b1;
                    phase_d = 4'd1;
                    state_d = StMmBurst;
                end
            end
            StMmBurst: begin
                pop = 1'b1;
                if (phase_q == 4'(MM_BURST_LEN - 1)) begin
                    phase_d = '0;
                    gap_d   = '0;
                    state_d = StMmGap;
                end else begin
                    phase_d = phase_q + 4'd1;
                end
            end
            StMmGap: begin
                if (gap_q == 4'(MM_GAP - 1)) begin
                    gap_d   = '0;
                    job_d   = job_q - 16'd1;
                    state_d = (job_q == 16'd1) ? StDone : StMmWait;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            StFirTap: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (phase_q == 4'(FIR_TAPS - 1)) begin
                        phase_d = '0;
                        state_d = StFirWait;
                    end else begin
                        phase_d = phase_q + 4'd1;
                    end
                end
            end
            StFirWait: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = StFirData;
                end
            end
            StFirData: begin
                // The cycle spent here is the first idle cycle of the gap (FIR_GAP >= 2).
                gap_d   = 4'd1;
                state_d = StFirGap;
            end
            StFirGap: begin
                if (gap_q == 4'(FIR_GAP - 1)) begin
                    gap_d   = '0;
                    job_d   = job_q - 16'd1;
                    state_d = (job_q == 16'd1) ? StDone : StFirWait;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        acc_data_d = acc_data_q;
        valid_d    = pop;
        if (pop) acc_data_d = fifo_rdata;
        busy_d = (state_d != StIdle);
        done_d = (state_q == StDone);
    end

    assign acc_data_o       = acc_data_q;
    assign acc_data_valid_o = valid_q;
    assign func_sel_o       = func_sel_q;
    assign busy             = busy_q;
    assign done             = done_q;

endmodule

// File: tb/tb_acc_feeder.sv
// Directed bench for acc_feeder: MM bursts, FIR taps/samples, FIFO full, zero count, reset.
module tb_acc_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        cfg_func_sel;
    logic [15:0] cfg_count;
    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic [31:0] acc_data_o;
    logic        acc_data_valid_o;
    logic        func_sel_o;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    acc_feeder #(
        .DATA_WIDTH(32),
        .FIFO_DEPTH(16),
        .MM_GAP    (8),
        .FIR_GAP   (6)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .cfg_func_sel    (cfg_func_sel),
        .cfg_count       (cfg_count),
        .s_tdata         (s_tdata),
        .s_tvalid        (s_tvalid),
        .s_tready        (s_tready),
        .acc_data_o      (acc_data_o),
        .acc_data_valid_o(acc_data_valid_o),
        .func_sel_o      (func_sel_o),
        .busy            (busy),
        .done            (done)
    );

    // Output monitor: records every valid word with its cycle stamp.
    logic [31:0] vq[$];
    int          vt[$];
    logic        fq[$];
    int          cyc = 0;
    int          done_cnt = 0;
    int          done_t = 0;

    always @(negedge clk) begin
        cyc++;
        if (acc_data_valid_o) begin
            vq.push_back(acc_data_o);
            vt.push_back(cyc);
            fq.push_back(func_sel_o);
        end
        if (done) begin
            done_cnt++;
            done_t = cyc;
        end
    end

    task automatic clear_mon();
        vq.delete();
        vt.delete();
        fq.delete();
        done_cnt = 0;
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic push_word(input logic [31:0] w);
        int k = 0;
        s_tdata  = w;
        s_tvalid = 1'b1;
        while (!s_tready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!s_tready) begin
            n_cmp++; n_err++;
            $display("FAIL push_timeout: s_tready=%b required 1 (word %0d)", s_tready, w);
        end
        @(negedge clk);
        s_tvalid = 1'b0;
    endtask

    task automatic start_job(input logic fs, input logic [15:0] cnt);
        start        = 1'b1;
        cfg_func_sel = fs;
        cfg_count    = cnt;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        for (int k = 0; k < limit && !done; k++) @(negedge clk);
        n_cmp++;
        if (!done) begin
            n_err++;
            $display("FAIL done_timeout: done=%b required 1", done);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (s_tready !== 1'b1) begin n_err++;
            $display("FAIL rst_tready: got %b want 1", s_tready); end
        n_cmp++; if (acc_data_valid_o !== 1'b0) begin n_err++;
            $display("FAIL rst_valid: got %b want 0", acc_data_valid_o); end
        n_cmp++; if (acc_data_o !== 32'd0) begin n_err++;
            $display("FAIL rst_data: got %0h want 0", acc_data_o); end
        n_cmp++; if (busy !== 1'b0) begin n_err++;
            $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++;
            $display("FAIL rst_done: got %b want 0", done); end
        n_cmp++; if (func_sel_o !== 1'b0) begin n_err++;
            $display("FAIL rst_func_sel: got %b want 0", func_sel_o); end
    endtask

    task automatic test_mm_count2();
        int want_dt;
        clear_mon();
        start_job(1'b0, 16'd2);
        n_cmp++; if (busy !== 1'b1) begin n_err++;
            $display("FAIL mm2_busy: got %b want 1", busy); end
        for (int i = 1; i <= 24; i++) push_word(32'(i));
        wait_done(200);
        n_cmp++;
        if (vq.size() != 24) begin
            n_err++;
            $display("FAIL mm2_count: got %0d words want 24", vq.size());
        end else begin
            for (int i = 0; i < 24; i++) begin
                n_cmp++; if (vq[i] !== 32'(i + 1)) begin n_err++;
                    $display("FAIL mm2_data[%0d]: got %0d want %0d", i, vq[i], i + 1); end
            end
            for (int i = 1; i < 24; i++) begin
                want_dt = (i == 12) ? 9 : 1;
                n_cmp++; if (vt[i] - vt[i-1] != want_dt) begin n_err++;
                    $display("FAIL mm2_spacing[%0d]: got %0d want %0d", i, vt[i] - vt[i-1],
                             want_dt); end
            end
            n_cmp++; if (done_t - vt[23] != 9) begin n_err++;
                $display("FAIL mm2_done_gap: got %0d want 9", done_t - vt[23]); end
            n_cmp++; if (fq[0] !== 1'b0) begin n_err++;
                $display("FAIL mm2_func_sel: got %b want 0", fq[0]); end
        end
        n_cmp++; if (done_cnt != 1) begin n_err++;
            $display("FAIL mm2_done_cnt: got %0d want 1", done_cnt); end
    endtask

    task automatic test_mm_partial();
        clear_mon();
        start_job(1'b0, 16'd1);
        for (int i = 201; i <= 211; i++) push_word(32'(i));
        repeat (10) @(negedge clk);
        n_cmp++; if (vq.size() != 0) begin n_err++;
            $display("FAIL part_early: got %0d words want 0", vq.size()); end
        n_cmp++; if (busy !== 1'b1) begin n_err++;
            $display("FAIL part_busy: got %b want 1", busy); end
        push_word(32'd212);
        n_cmp++; if (acc_data_valid_o !== 1'b0) begin n_err++;
            $display("FAIL part_valid_push: got %b want 0", acc_data_valid_o); end
        @(negedge clk);
        n_cmp++; if (acc_data_valid_o !== 1'b1 || acc_data_o !== 32'd201) begin n_err++;
            $display("FAIL part_first: got valid=%b data=%0d want valid=1 data=201",
                     acc_data_valid_o, acc_data_o); end
        wait_done(100);
        n_cmp++;
        if (vq.size() != 12) begin
            n_err++;
            $display("FAIL part_count: got %0d words want 12", vq.size());
        end else begin
            for (int i = 0; i < 12; i++) begin
                n_cmp++; if (vq[i] !== 32'(201 + i)) begin n_err++;
                    $display("FAIL part_data[%0d]: got %0d want %0d", i, vq[i], 201 + i); end
            end
            n_cmp++; if (vt[11] - vt[0] != 11) begin n_err++;
                $display("FAIL part_contig: got %0d want 11", vt[11] - vt[0]); end
        end
    endtask

    task automatic test_fir3();
        int want_dt;
        clear_mon();
        for (int i = 100; i <= 113; i++) push_word(32'(i));
        start_job(1'b1, 16'd3);
        n_cmp++; if (func_sel_o !== 1'b1 || acc_data_valid_o !== 1'b0) begin n_err++;
            $display("FAIL fir_pre: got func_sel=%b valid=%b want 1/0", func_sel_o,
                     acc_data_valid_o); end
        wait_done(200);
        n_cmp++;
        if (vq.size() != 14) begin
            n_err++;
            $display("FAIL fir_count: got %0d words want 14", vq.size());
        end else begin
            for (int i = 0; i < 14; i++) begin
                n_cmp++; if (vq[i] !== 32'(100 + i)) begin n_err++;
                    $display("FAIL fir_data[%0d]: got %0d want %0d", i, vq[i], 100 + i); end
            end
            for (int i = 1; i < 14; i++) begin
                want_dt = (i >= 12) ? 7 : 1;
                n_cmp++; if (vt[i] - vt[i-1] != want_dt) begin n_err++;
                    $display("FAIL fir_spacing[%0d]: got %0d want %0d", i, vt[i] - vt[i-1],
                             want_dt); end
            end
            n_cmp++; if (done_t - vt[13] != 7) begin n_err++;
                $display("FAIL fir_done_gap: got %0d want 7", done_t - vt[13]); end
        end
        n_cmp++; if (done_cnt != 1) begin n_err++;
            $display("FAIL fir_done_cnt: got %0d want 1", done_cnt); end
        repeat (3) @(negedge clk);
        n_cmp++; if (func_sel_o !== 1'b1 || busy !== 1'b0) begin n_err++;
            $display("FAIL fir_hold: got func_sel=%b busy=%b want 1/0", func_sel_o, busy); end
    endtask

    task automatic test_count_zero();
        clear_mon();
        start_job(1'b0, 16'd0);
        n_cmp++; if (busy !== 1'b1 || done !== 1'b0) begin n_err++;
            $display("FAIL zero_t1: got busy=%b done=%b want 1/0", busy, done); end
        n_cmp++; if (func_sel_o !== 1'b0) begin n_err++;
            $display("FAIL zero_func_sel: got %b want 0", func_sel_o); end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || done !== 1'b1) begin n_err++;
            $display("FAIL zero_t2: got busy=%b done=%b want 0/1", busy, done); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b0) begin n_err++;
            $display("FAIL zero_t3: got done=%b want 0", done); end
        n_cmp++; if (vq.size() != 0) begin n_err++;
            $display("FAIL zero_valid: got %0d words want 0", vq.size()); end
    endtask

    task automatic test_fifo_full();
        clear_mon();
        for (int i = 301; i <= 316; i++) push_word(32'(i));
        n_cmp++; if (s_tready !== 1'b0) begin n_err++;
            $display("FAIL full_tready: got %b want 0", s_tready); end
        fork
            start_job(1'b0, 16'd2);
            for (int i = 317; i <= 324; i++) push_word(32'(i));
        join
        wait_done(200);
        n_cmp++;
        if (vq.size() != 24) begin
            n_err++;
            $display("FAIL full_count: got %0d words want 24", vq.size());
        end else begin
            for (int i = 0; i < 24; i++) begin
                n_cmp++; if (vq[i] !== 32'(301 + i)) begin n_err++;
                    $display("FAIL full_data[%0d]: got %0d want %0d", i, vq[i], 301 + i); end
            end
        end
        n_cmp++; if (s_tready !== 1'b1) begin n_err++;
            $display("FAIL full_tready_end: got %b want 1", s_tready); end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        clear_mon();
        for (int i = 401; i <= 414; i++) push_word(32'(i));
        start_job(1'b0, 16'd1);
        for (int k = 0; k < 50 && seen < 5; k++) begin
            @(negedge clk);
            if (acc_data_valid_o) seen++;
        end
        n_cmp++; if (seen != 5 || acc_data_o !== 32'd405) begin n_err++;
            $display("FAIL rmid_fifth: got seen=%0d data=%0d want 5/405", seen, acc_data_o); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (acc_data_valid_o !== 1'b0 || busy !== 1'b0) begin n_err++;
            $display("FAIL rmid_out: got valid=%b busy=%b want 0/0", acc_data_valid_o, busy); end
        n_cmp++; if (s_tready !== 1'b1 || done !== 1'b0) begin n_err++;
            $display("FAIL rmid_flags: got tready=%b done=%b want 1/0", s_tready, done); end
        // FIR taps pop anything buffered, so any leftover word would reappear here.
        start_job(1'b1, 16'd1);
        repeat (20) @(negedge clk);
        n_cmp++; if (vq.size() != 5) begin n_err++;
            $display("FAIL rmid_fifo_empty: got %0d words want 5", vq.size()); end
        n_cmp++; if (done_cnt != 0 || busy !== 1'b1) begin n_err++;
            $display("FAIL rmid_no_done: got done_cnt=%0d busy=%b want 0/1", done_cnt, busy); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        cfg_func_sel = 1'b0;
        cfg_count    = 16'd0;
        s_tdata      = 32'd0;
        s_tvalid     = 1'b0;
        @(negedge clk);
        test_reset();
        test_mm_count2();
        test_mm_partial();
        test_fir3();
        test_count_zero();
        test_fifo_full();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
